counter_stim_checker: RTL
=========================

Name: counter_stim_checker

Overview:
- Stimulus-and-check end of the 4-bit mode counter interface. It generates the enable/reset/mode/D sequence that drives both the counter DUT and its behavioural scoreboard model.
- It then compares the DUT's Q/load/rco against the model's outputs cycle by cycle and counts mismatches.
- Synthesizable, so the same self-check can run on the gate-level counter in simulation or on FPGA.

Parameters:
- RESET_LEN, 2, cycles of counter reset at the start of a run (min 1)
- PHASE_LEN, 20, cycles spent in each of the up, down and up-by-3 modes (min 1)
- LOAD_LEN, 8, cycles spent in load mode (min 1)
- LFSR_SEED, 4'b1001, initial value of the D-generation LFSR; a seed of 0 is replaced by 4'b0001

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin a run; sampled only in IDLE or DONE
- dut_q  in  4  counter DUT Q
- dut_load  in  1  counter DUT load
- dut_rco  in  1  counter DUT rco
- ref_q  in  4  scoreboard model Q
- ref_load  in  1  scoreboard model load
- ref_rco  in  1  scoreboard model rco
- cnt_enable  out  1  enable to DUT and model
- cnt_reset  out  1  reset to DUT and model
- cnt_mode  out  2  mode to DUT and model
- cnt_d  out  4  load data to DUT and model
- busy  out  1  run in progress
- done  out  1  run complete, err_count final
- err_count  out  8  saturating mismatch count
- err_flag  out  1  err_count != 0

Behaviour:
- All outputs registered.
- Reset values:
  - cnt_enable=0, cnt_reset=1, cnt_mode=00, cnt_d=0
  - busy=0, done=0, err_count=0, err_flag=0
  - LFSR=seed, state=IDLE
- FSM states: IDLE, RST, UP, DOWN, UP3, LOAD, MIDRST, DRAIN, DONE.
- IDLE/DONE drive: cnt_enable=0, cnt_reset=1, cnt_mode=00, cnt_d=0.
- start=1 in IDLE or DONE:
  - go to RST next cycle
  - clear err_count, err_flag and done
  - reload LFSR with the seed
- start is ignored in every other state.
- Per-state drive and duration (each state drives cnt_enable=1 unless noted):
  - RST: RESET_LEN cycles; cnt_reset=1, mode 00
  - UP: PHASE_LEN cycles; cnt_reset=0, mode 00
  - DOWN: PHASE_LEN cycles; mode 01
  - UP3: PHASE_LEN cycles; mode 10
  - LOAD: LOAD_LEN cycles; mode 11; cnt_d=LFSR, LFSR advances every LOAD cycle
  - MIDRST: 1 cycle; mode 11, cnt_reset=1, cnt_d=LFSR (reset has priority over load)
  - DRAIN: 1 cycle; idle drive
  - DONE: holds until start or reset
- LFSR rule: next = {lfsr[2:0], lfsr[3]^lfsr[2]}. From the default seed, cnt_d reads 1001, 0011, 0110, 1101, ...
- Phase counter: one down-counter, loaded on each state entry, transition taken when it reaches 1. Its width must fit max(RESET_LEN, PHASE_LEN, LOAD_LEN).
- busy=1 from the first RST cycle through DRAIN inclusive. Total busy cycles = RESET_LEN + 3*PHASE_LEN + LOAD_LEN + 2 (72 with defaults).
- done goes high on the first DONE cycle and stays high until a new start or reset.
- Compare window:
  - cmp_valid = registered "state in RST..MIDRST", so each stimulus cycle is checked one cycle later, when the DUT/model have responded. The last compare happens in DRAIN.
  - A mismatch is any difference in the 6-bit tuple {q, load, rco}.
  - On a mismatch, err_count increments by 1, saturating at 255.
  - err_flag is registered from the next err_count value, i.e. it rises in the same cycle err_count leaves 0.
- Inputs are not compared outside cmp_valid.
- reset mid-run: return to IDLE the next cycle with reset values, regardless of state. The partial err_count is discarded.
- reset and start asserted together: reset wins.

Test Plan:
- Clean run: start pulsed, default params, dut_* tied to a correct counter equal to the model → busy high 72 cycles, then done=1, err_count=0, err_flag=0; cnt_mode sequence 00×22, 01×20, 10×20, 11×9.
- LFSR/load check: default seed → cnt_d in LOAD = 1001, 0011, 0110, 1101, ...; cnt_reset=1 with mode 11 in the MIDRST cycle.
- Single injection: force dut_q = ref_q^1 for exactly one cycle inside UP → final err_count=1, err_flag rises the cycle after the bad sample.
- Stuck rco: dut_rco tied 0 → err_count equals the number of compare cycles where ref_rco=1, err_flag=1 at done.
- Saturation/restart: PHASE_LEN=100 with dut_q inverted permanently → err_count=255. Then a start pulse in DONE clears it to 0, and a clean rerun ends with 0.
- Reset mid-run: assert reset during DOWN → next cycle IDLE, busy=0, cnt_reset=1, err_count=0. start during busy is ignored, shown by the phase timing being unchanged.

Source files
------------

// File: rtl/counter_stim_checker_if.sv
// counter_stim_checker_if: stimulus to a 4-bit mode counter and its model, and both responses back.
interface counter_stim_checker_if;
    logic       cnt_enable;
    logic       cnt_reset;
    logic [1:0] cnt_mode;
    logic [3:0] cnt_d;
    logic [3:0] dut_q;
    logic       dut_load;
    logic       dut_rco;
    logic [3:0] ref_q;
    logic       ref_load;
    logic       ref_rco;
    modport master (
        output cnt_enable, cnt_reset, cnt_mode, cnt_d,
        input  dut_q, dut_load, dut_rco, ref_q, ref_load, ref_rco
    );
    modport slave (
        input  cnt_enable, cnt_reset, cnt_mode, cnt_d,
        output dut_q, dut_load, dut_rco, ref_q, ref_load, ref_rco
    );
endinterface

// File: rtl/counter_stim_checker.sv
// counter_stim_checker: sequences reset/up/down/up3/load stimulus into a counter and its model,
// then counts cycle-by-cycle mismatches of {q, load, rco} one cycle after each stimulus cycle.
module counter_stim_checker #(
    parameter int         RESET_LEN = 2,
    parameter int         PHASE_LEN = 20,
    parameter int         LOAD_LEN  = 8,
    parameter logic [3:0] LFSR_SEED = 4'b1001
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    counter_stim_checker_if.master        cif,
    output logic                          busy,
    output logic                          done,
    output logic [7:0]                    err_count,
    output logic                          err_flag
);
    localparam logic [3:0] SEED = (LFSR_SEED == 4'd0) ? 4'd1 : LFSR_SEED;
    localparam int RP   = (RESET_LEN > PHASE_LEN) ? RESET_LEN : PHASE_LEN;
    localparam int MAXL = (RP > LOAD_LEN) ? RP : LOAD_LEN;
    localparam int PW   = $clog2(MAXL + 1);
    typedef enum logic [3:0] {IDLE, RST, UP, DOWN, UP3, LOAD, MIDRST, DRAIN, DONE} state_t;
    state_t        state_q, state_d;
    logic [PW-1:0] ph_q, ph_d;
    logic [3:0]    lfsr_q, lfsr_d;
    logic          en_q, en_d, crst_q, crst_d;
    logic [1:0]    mode_q, mode_d;
    logic [3:0]    d_q, d_d;
    logic          busy_q, busy_d, done_q, done_d, cmp_q, cmp_d, flag_q, flag_d;
    logic [7:0]    err_q, err_d;
    logic          clr, last, mismatch;
    function automatic logic [PW-1:0] len(state_t s);
        return (s == RST) ? PW'(RESET_LEN) :
               (s == LOAD) ? PW'(LOAD_LEN) :
               (s inside {UP, DOWN, UP3}) ? PW'(PHASE_LEN) : PW'(1);
    endfunction
    always_comb begin
        clr      = (state_q inside {IDLE, DONE}) && start;
        last     = ph_q == PW'(1);
        // active states are consecutive in the enum, so advancing is just +1
        state_d  = clr ? RST :
                   ((state_q inside {IDLE, DONE}) || !last) ? state_q : state_t'(state_q + 4'd1);
        ph_d     = (state_d != state_q) ? len(state_d) : last ? ph_q : ph_q - PW'(1);
        lfsr_d   = clr ? SEED : (state_q == LOAD) ? {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]} : lfsr_q;
        en_d     = state_d inside {RST, UP, DOWN, UP3, LOAD, MIDRST};
        crst_d   = !(state_d inside {UP, DOWN, UP3, LOAD});
        mode_d   = (state_d == DOWN) ? 2'b01 : (state_d == UP3) ? 2'b10 :
                   (state_d inside {LOAD, MIDRST}) ? 2'b11 : 2'b00;
        d_d      = (state_d inside {LOAD, MIDRST}) ? lfsr_d : 4'd0;
        busy_d   = state_d inside {RST, UP, DOWN, UP3, LOAD, MIDRST, DRAIN};
        done_d   = state_d == DONE;
        cmp_d    = state_q inside {RST, UP, DOWN, UP3, LOAD, MIDRST};
        mismatch = {cif.dut_q, cif.dut_load, cif.dut_rco} != {cif.ref_q, cif.ref_load, cif.ref_rco};
        err_d    = clr ? 8'd0 : (cmp_q && mismatch && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
        flag_d   = err_d != 8'd0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ph_q    <= PW'(1);
            lfsr_q  <= SEED;
            en_q    <= 1'b0;
            crst_q  <= 1'b1;
            mode_q  <= 2'b00;
            d_q     <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cmp_q   <= 1'b0;
            err_q   <= 8'd0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            lfsr_q  <= lfsr_d;
            en_q    <= en_d;
            crst_q  <= crst_d;
            mode_q  <= mode_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cmp_q   <= cmp_d;
            err_q   <= err_d;
            flag_q  <= flag_d;
        end
    end
    assign cif.cnt_enable = en_q;
    assign cif.cnt_reset  = crst_q;
    assign cif.cnt_mode   = mode_q;
    assign cif.cnt_d      = d_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_count      = err_q;
    assign err_flag       = flag_q;
endmodule
